// File: rtl/mean_filter_mc.sv
// mean_filter_mc: streaming KxK box filter, AXI4-Stream in/out, per-channel.
// Emits the valid-window crop: (W-K+1) x (H-K+1) outputs per frame.
// Optional build macro MF_ROUND_EN selects round-half-up instead of a
// truncating divide.
//
// Handshake: ce = !m_axis_tvalid || m_axis_tready, and s_axis_tready = ce.
// Every register in the pipeline advances only on ce. An input beat is
// accepted when s_axis_tvalid && ce. An output beat is consumed when
// m_axis_tvalid && m_axis_tready. Output data and flags hold while stalled.
//
// Latency: m_axis_tvalid rises on the 4th ce edge after the edge that
// accepted the window's bottom-right pixel.
// Pipeline: window -> row sums -> total -> quotient -> output register.
module mean_filter_mc #(
    parameter int DATA_WIDTH   = 8,
    parameter int CHANNELS     = 1,
    parameter int WINDOW_SIZE  = 3,
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 512
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           bypass,
    input  logic [CHANNELS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                           s_axis_tvalid,
    input  logic                           s_axis_tlast,
    input  logic                           s_axis_tuser,
    output logic                           s_axis_tready,
    output logic [CHANNELS*DATA_WIDTH-1:0] m_axis_tdata,
    output logic                           m_axis_tvalid,
    output logic                           m_axis_tlast,
    output logic                           m_axis_tuser,
    input  logic                           m_axis_tready,
    output logic                           frame_err
);
    localparam int K     = WINDOW_SIZE;
    localparam int KK    = K * K;
    localparam int TW    = CHANNELS * DATA_WIDTH;
    localparam int SUM_W = DATA_WIDTH + $clog2(KK);
    localparam int CW    = $clog2(FRAME_WIDTH);
    localparam int RW    = $clog2(FRAME_HEIGHT);
    localparam int MID   = (K - 1) / 2;
`ifdef MF_ROUND_EN
    localparam int BIAS  = KK / 2;
`else
    localparam int BIAS  = 0;
`endif

    generate
        if (!(K == 3 || K == 5 || K == 7)) begin : g_bad_window
            $error("mean_filter_mc: WINDOW_SIZE must be 3, 5 or 7");
        end
    endgenerate

    logic            ce, live, active_q, at_eol, at_eof, win_ok;
    logic [CW-1:0]   col_q, cur_col;
    logic [RW-1:0]   row_q, cur_row;
    logic [TW-1:0]   lb_q [K-1][FRAME_WIDTH];
    logic [TW-1:0]   col_vec [K];
    logic [DATA_WIDTH-1:0] win_q [CHANNELS][K][K];
    logic s1_valid_q, s1_last_q, s1_user_q, s1_byp_q;
    logic s2_valid_q, s2_last_q, s2_user_q, s2_byp_q;
    logic s3_valid_q, s3_last_q, s3_user_q, s3_byp_q;
    logic s4_valid_q, s4_last_q, s4_user_q;
    logic [SUM_W-1:0] rsum_d [CHANNELS][K];
    logic [SUM_W-1:0] rsum_q [CHANNELS][K];
    logic [SUM_W-1:0] tot_d  [CHANNELS];
    logic [SUM_W-1:0] tot_q  [CHANNELS];
    logic [DATA_WIDTH-1:0] mid2_q [CHANNELS];
    logic [DATA_WIDTH-1:0] mid3_q [CHANNELS];
    logic [TW-1:0]   res_d, res4_q;

    assign ce            = !m_axis_tvalid || m_axis_tready;
    assign s_axis_tready = ce;

    // Position of the incoming pixel; tuser forces it to (0,0).
    always_comb begin
        cur_col = s_axis_tuser ? '0 : col_q;
        cur_row = s_axis_tuser ? '0 : row_q;
        at_eol  = (cur_col == CW'(FRAME_WIDTH - 1));
        at_eof  = (cur_row == RW'(FRAME_HEIGHT - 1));
        live    = s_axis_tvalid && ce && (s_axis_tuser || active_q);
        win_ok  = live && (cur_row >= RW'(K - 1)) && (cur_col >= CW'(K - 1));
    end

    // New window column: oldest line buffer on top, incoming pixel at bottom.
    always_comb begin
        for (int i = 0; i < K - 1; i++) begin
            col_vec[i] = lb_q[K-2-i][cur_col];
        end
        col_vec[K-1] = s_axis_tdata;
    end

    // Row/column counters follow the internal width count; tlast only feeds frame_err.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q     <= '0;
            row_q     <= '0;
            active_q  <= 1'b0;
            frame_err <= 1'b0;
        end else if (live) begin
            active_q <= 1'b1;
            col_q    <= at_eol ? '0 : cur_col + 1'b1;
            if (at_eol) begin
                row_q <= at_eof ? '0 : cur_row + 1'b1;
            end else begin
                row_q <= cur_row;
            end
            if (s_axis_tlast != at_eol) begin
                frame_err <= 1'b1;
            end
        end
    end

    // Line buffers and window registers shift once per live pixel.
    always_ff @(posedge clk) begin
        if (live) begin
            lb_q[0][cur_col] <= s_axis_tdata;
            for (int j = 1; j < K - 1; j++) begin
                lb_q[j][cur_col] <= lb_q[j-1][cur_col];
            end
            for (int ch = 0; ch < CHANNELS; ch++) begin
                for (int i = 0; i < K; i++) begin
                    for (int j = 0; j < K - 1; j++) begin
                        win_q[ch][i][j] <= win_q[ch][i][j+1];
                    end
                    win_q[ch][i][K-1] <= col_vec[i][ch*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Per-channel row sums, total (with rounding bias) and quotient or bypass.
    always_comb begin
        for (int ch = 0; ch < CHANNELS; ch++) begin
            tot_d[ch] = SUM_W'(BIAS);
            for (int i = 0; i < K; i++) begin
                rsum_d[ch][i] = '0;
                for (int j = 0; j < K; j++) begin
                    rsum_d[ch][i] = rsum_d[ch][i] + SUM_W'(win_q[ch][i][j]);
                end
                tot_d[ch] = tot_d[ch] + rsum_q[ch][i];
            end
        end
        res_d = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            res_d[ch*DATA_WIDTH +: DATA_WIDTH] = s3_byp_q ? mid3_q[ch]
                : DATA_WIDTH'(tot_q[ch] / SUM_W'(KK));
        end
    end

    // Pipeline control flags; cleared on reset so in-flight data is discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            {s1_valid_q, s1_last_q, s1_user_q, s1_byp_q} <= '0;
            {s2_valid_q, s2_last_q, s2_user_q, s2_byp_q} <= '0;
            {s3_valid_q, s3_last_q, s3_user_q, s3_byp_q} <= '0;
            {s4_valid_q, s4_last_q, s4_user_q}           <= '0;
        end else if (ce) begin
            s1_valid_q <= win_ok;
            s1_last_q  <= win_ok && at_eol;
            s1_user_q  <= win_ok && (cur_row == RW'(K - 1)) && (cur_col == CW'(K - 1));
            s1_byp_q   <= bypass;
            {s2_valid_q, s2_last_q, s2_user_q, s2_byp_q} <= {s1_valid_q, s1_last_q, s1_user_q, s1_byp_q};
            {s3_valid_q, s3_last_q, s3_user_q, s3_byp_q} <= {s2_valid_q, s2_last_q, s2_user_q, s2_byp_q};
            {s4_valid_q, s4_last_q, s4_user_q}           <= {s3_valid_q, s3_last_q, s3_user_q};
        end
    end

    // Pipeline datapath registers; qualified by the flag pipeline above.
    always_ff @(posedge clk) begin
        if (ce) begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                for (int i = 0; i < K; i++) begin
                    rsum_q[ch][i] <= rsum_d[ch][i];
                end
                mid2_q[ch] <= win_q[ch][MID][MID];
                tot_q[ch]  <= tot_d[ch];
                mid3_q[ch] <= mid2_q[ch];
            end
            res4_q <= res_d;
        end
    end

    // Output register: loads on ce, holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
        end else if (ce) begin
            m_axis_tvalid <= s4_valid_q;
            m_axis_tdata  <= res4_q;
            m_axis_tlast  <= s4_last_q;
            m_axis_tuser  <= s4_user_q;
        end
    end

endmodule

// File: tb/tb_mean_filter_mc.sv
// tb_mean_filter_mc: randomized bench for mean_filter_mc (W=8, H=6, K=3, 3 channels)
// with a frame-array reference model and an expected-output queue.
module tb_mean_filter_mc;
    localparam int W  = 8;
    localparam int H  = 6;
    localparam int K  = 3;
    localparam int CH = 3;
    localparam int DW = 8;
    localparam int TW = CH * DW;
    localparam int EW = 32 + 2 + TW;

    logic          clk = 1'b0;
    logic          rst, bypass, s_tvalid, s_tlast, s_tuser, s_tready;
    logic [TW-1:0] s_tdata, m_data;
    logic          m_valid, m_last, m_user, m_ready, frame_err;

    mean_filter_mc #(
        .DATA_WIDTH(DW), .CHANNELS(CH), .WINDOW_SIZE(K),
        .FRAME_WIDTH(W), .FRAME_HEIGHT(H)
    ) dut (
        .clk(clk), .rst(rst), .bypass(bypass),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
        .s_axis_tuser(s_tuser), .s_axis_tready(s_tready),
        .m_axis_tdata(m_data), .m_axis_tvalid(m_valid), .m_axis_tlast(m_last),
        .m_axis_tuser(m_user), .m_axis_tready(m_ready), .frame_err(frame_err)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    int passes = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // reference model state
    logic [EW-1:0] exp_q[$];
    logic [DW-1:0] img [CH][H][W];
    bit            m_active, exp_err, byp_mode, lat_chk, hold_pend;
    int            m_row, m_col, rmode, n_out;
    logic [TW-1:0] first_out;
    logic [63:0]   held;

    // Accepted pixel -> frame store; when a full KxK window exists, queue its mean.
    task automatic model_accept(input logic [TW-1:0] d, input bit last, input bit user,
                                input bit byp, input int edge_n);
        logic [TW-1:0] res;
        int sum;
        if (user) begin
            m_active = 1'b1;
            m_row = 0;
            m_col = 0;
        end
        if (m_active) begin
            for (int c = 0; c < CH; c++) img[c][m_row][m_col] = d[c*DW +: DW];
            if (last != (m_col == W - 1)) exp_err = 1'b1;
            if (m_row >= K - 1 && m_col >= K - 1) begin
                res = '0;
                for (int c = 0; c < CH; c++) begin
                    sum = 0;
                    for (int dr = 0; dr < K; dr++)
                        for (int dc = 0; dc < K; dc++)
                            sum += int'(img[c][m_row-dr][m_col-dc]);
`ifdef MF_ROUND_EN
                    sum += (K * K) / 2;
`endif
                    res[c*DW +: DW] = byp ? img[c][m_row-(K-1)/2][m_col-(K-1)/2]
                                          : DW'(sum / (K * K));
                end
                exp_q.push_back({32'(edge_n), (m_row == K - 1 && m_col == K - 1),
                                 (m_col == W - 1), res});
            end
            m_col++;
            if (m_col == W) begin
                m_col = 0;
                m_row = (m_row == H - 1) ? 0 : m_row + 1;
            end
        end
    endtask

    // output ready pattern: 0 always ready, 1 toggle, 2 random stalls
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                1:       m_ready = ~m_ready;
                2:       m_ready = ($urandom_range(0, 3) != 0);
                default: m_ready = 1'b1;
            endcase
        end
    end

    // scoreboard / monitor
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (rst) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) check("hold", {m_valid, m_last, m_user, m_data}, held);
            if (m_valid && m_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("data", m_data, e[TW-1:0]);
                    check("tlast", m_last, e[TW]);
                    check("tuser", m_user, e[TW+1]);
                    if (lat_chk) check("latency", cyc - int'(e[EW-1 -: 32]), 4);
                    if (m_user) first_out = m_data;
                end
            end
            hold_pend = m_valid && !m_ready;
            held      = {m_valid, m_last, m_user, m_data};
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_pix(input logic [TW-1:0] d, input bit last, input bit user);
        int n = 0;
        bit done = 1'b0;
        s_tdata = d; s_tlast = last; s_tuser = user; s_tvalid = 1'b1; bypass = byp_mode;
        while (!done) begin
            @(negedge clk);
            if (s_tready) begin
                model_accept(d, last, user, byp_mode, cyc + 1);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            n++;
            if (!done && n > 200) begin
                check("accept_timeout", 1, 0);
                done = 1'b1;
            end
        end
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
    endtask

    function automatic logic [TW-1:0] pix_val(input int kind, input int r, input int c);
        logic [TW-1:0] v;
        for (int ch = 0; ch < CH; ch++) begin
            case (kind)
                0:       v[ch*DW +: DW] = 8'd100;
                1:       v[ch*DW +: DW] = DW'((r + c + ch * 10) % 256);
                2:       v[ch*DW +: DW] = (r == 2 && c == 2) ? DW'(ch == 0 ? 5 : (ch == 1 ? 6 : 1)) : 8'd1;
                default: v[ch*DW +: DW] = DW'($urandom_range(0, 255));
            endcase
        end
        return v;
    endfunction

    // One frame; stops early before (stop_r,stop_c); extra tlast at (1,bad_col).
    task automatic send_frame(input int kind, input bit gaps, input int bad_col,
                              input int stop_r, input int stop_c);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r == stop_r && c == stop_c) return;
                send_pix(pix_val(kind, r, c), (c == W - 1) || (r == 1 && c == bad_col),
                         (r == 0 && c == 0));
                if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", exp_q.size(), 0);
        idle(3);
    endtask

    task automatic do_reset();
        s_tvalid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_tvalid", m_valid, 0);
        check("rst_tdata", m_data, 0);
        check("rst_tlast", m_last, 0);
        check("rst_tuser", m_user, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_tready", s_tready, 1);
        rst = 1'b0;
        exp_q.delete();
        m_active = 1'b0; exp_err = 1'b0; m_row = 0; m_col = 0;
    endtask

    // main sequence
    initial begin
        int base;
        rst = 1'b1; bypass = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
        s_tdata = '0; rmode = 0; n_out = 0; lat_chk = 1'b1; byp_mode = 1'b0;
        m_active = 1'b0; exp_err = 1'b0; m_row = 0; m_col = 0; first_out = '0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // pre-tuser pixels are dropped; constant frame
        for (int i = 0; i < 5; i++) send_pix(pix_val(3, 0, i), 1'b0, 1'b0);
        base = n_out;
        send_frame(0, 1'b0, -1, H, 0);
        drain();
        check("const_count", n_out - base, (W - K + 1) * (H - K + 1));
        check("const_first", first_out, {3{8'd100}});
        check("frame_err_clean", frame_err, exp_err);

        // ramp frame, per-channel offsets
        send_frame(1, 1'b0, -1, H, 0);
        drain();
        check("ramp_ch0", first_out[7:0], 2);
        check("ramp_ch1", first_out[15:8], 12);
        check("ramp_ch2", first_out[23:16], 22);

        // rounding boundary: sums 13 and 14
        send_frame(2, 1'b0, -1, H, 0);
        drain();
        check("sum13", first_out[7:0], 1);
`ifdef MF_ROUND_EN
        check("sum14", first_out[15:8], 2);
`else
        check("sum14", first_out[15:8], 1);
`endif

        // backpressure: toggled then random ready with input gaps
        lat_chk = 1'b0;
        rmode = 1;
        send_frame(1, 1'b1, -1, H, 0);
        drain();
        rmode = 2;
        send_frame(3, 1'b1, -1, H, 0);
        send_frame(1, 1'b1, -1, H, 0);
        drain();
        rmode = 0;
        idle(2);

        // bypass frame, latency checked
        lat_chk = 1'b1;
        byp_mode = 1'b1;
        send_frame(3, 1'b0, -1, H, 0);
        drain();
        byp_mode = 1'b0;

        // tuser restart at row 3 col 2
        base = n_out;
        send_frame(1, 1'b0, -1, 3, 2);
        send_frame(3, 1'b0, -1, H, 0);
        drain();
        check("restart_count", n_out - base, (W - K + 1) + (W - K + 1) * (H - K + 1));
        check("restart_frame_err", frame_err, 0);

        // early tlast sets sticky frame_err
        send_frame(1, 1'b0, 5, H, 0);
        drain();
        check("bad_tlast_err", frame_err, 1);
        check("model_err", frame_err, exp_err);
        send_frame(1, 1'b0, -1, H, 0);
        drain();
        check("err_sticky", frame_err, 1);

        // reset mid-frame with stalls, then untagged pixels and a fresh frame
        rmode = 2;
        lat_chk = 1'b0;
        send_frame(3, 1'b0, -1, 3, 4);
        rmode = 0;
        do_reset();
        lat_chk = 1'b1;
        base = n_out;
        for (int i = 0; i < 6; i++) send_pix(pix_val(3, 0, i), 1'b0, 1'b0);
        idle(8);
        check("post_rst_drop", n_out - base, 0);
        send_frame(1, 1'b0, -1, H, 0);
        drain();
        check("post_rst_count", n_out - base, (W - K + 1) * (H - K + 1));
        check("post_rst_err", frame_err, 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
